// File: rtl/mux_rr.sv
// mux_rr: CHANNELS-to-1, WIDTH-bit registered multiplexer with per-channel
// valid/ready handshakes. mode = 0 forwards the channel picked by sel;
// mode = 1 arbitrates round-robin among the valid channels.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode
//   in_data    packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel word-available flags
//   in_ready   per-channel accept strobes (combinational, at most one high)
//   out_data   registered output word
//   out_ch     channel that supplied out_data
//   out_valid  output register occupied
//   out_ready  consumer accepts the word this cycle
module mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] grant;
    logic            grant_vld;
    logic            load_en;

    assign load_en = !out_valid || out_ready;

    // Round-robin search runs from the farthest candidate (ptr itself) down to
    // the nearest (ptr+1) so the last hit, i.e. the highest-priority one, wins.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        if (mode) begin
            for (int k = CHANNELS; k >= 1; k--) begin
                if (in_valid[(int'(ptr) + k) % CHANNELS]) begin
                    grant_vld = 1'b1;
                    grant     = SELW'((int'(ptr) + k) % CHANNELS);
                end
            end
        end else if (int'(sel) < CHANNELS) begin
            if (in_valid[sel]) begin
                grant_vld = 1'b1;
                grant     = sel;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && grant_vld && load_en) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(CHANNELS - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
                out_ch    <= grant;
                out_valid <= 1'b1;
                if (mode) begin
                    ptr <= grant;
                end
            end else begin
                // Nothing to load: empty the register but keep the last word.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr.sv
module tb_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    int n_checks = 0;
    int n_fail   = 0;

    bit        m_valid;
    int        m_ptr;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    mux_rr #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_rr #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arbiter: walk the channels in priority order from the model pointer.
    task automatic model_grant(output bit gv, output int g);
        gv = 0;
        g  = 0;
        if (mode) begin
            int i;
            i = m_ptr;
            repeat (4) begin
                i = (i == 3) ? 0 : i + 1;
                if (!gv && in_valid[i]) begin
                    gv = 1;
                    g  = i;
                end
            end
        end else if (in_valid[sel]) begin
            gv = 1;
            g  = int'(sel);
        end
    endtask

    // One clock: check handshake/outputs against the model, update scoreboard,
    // advance to the next falling edge.
    task automatic cycle();
        bit         gv;
        int         g;
        bit         le;
        logic [3:0] exp_rdy;
        logic [9:0] exp_word;
        #1;
        check("out_valid", out_valid, m_valid);
        le = !m_valid || out_ready;
        model_grant(gv, g);
        exp_rdy = (rst_n && gv && le) ? (4'b0001 << g) : 4'b0000;
        check("in_ready", in_ready, exp_rdy);
        if (rst_n && m_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 0, 1);
            end else begin
                exp_word = sb.pop_front();
                check("out_data", out_data, exp_word[9:2]);
                check("out_ch", out_ch, exp_word[1:0]);
            end
        end
        if (!rst_n) begin
            m_valid = 0;
            m_ptr   = 3;
            sb.delete();
        end else if (le) begin
            if (gv) begin
                sb.push_back({in_data[g*8 +: 8], 2'(g)});
                m_valid = 1;
                if (mode) m_ptr = g;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seq4[6] = '{0, 1, 2, 3, 0, 1};
        int seq2[4] = '{1, 3, 1, 3};

        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        in_data   = {8'h40, 8'h30, 8'h20, 8'h10};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        mode3     = 1'b0;
        sel3      = 2'd3;
        in_data3  = {8'hc3, 8'hb2, 8'ha1};
        in_valid3 = 3'b111;
        out_ready3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_valid = 0;
        m_ptr   = 3;

        // Reset with every channel requesting
        do_reset(2);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_ch", out_ch, 0);

        // CHANNELS = 3, sel out of range: never a grant
        for (int i = 0; i < 3; i++) begin
            #1;
            check("c3_in_ready", in_ready3, 3'b000);
            check("c3_out_valid", out_valid3, 0);
            cycle();
        end

        // Fixed mode, sel = 2
        mode = 1'b0;
        sel  = 2'd2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("fix_out_data", out_data, 8'h30);
            check("fix_out_ch", out_ch, 2);
        end
        sel      = 2'd1;
        in_valid = 4'b1101;
        cycle();
        check("fix_idle_valid", out_valid, 0);

        // Round-robin rotation
        do_reset(1);
        mode     = 1'b1;
        in_valid = 4'b1111;
        foreach (seq4[i]) begin
            cycle();
            check("rr_valid", out_valid, 1);
            check("rr_seq", out_ch, seq4[i]);
        end

        // Skip idle channels
        do_reset(1);
        in_valid = 4'b1010;
        foreach (seq2[i]) begin
            cycle();
            check("skip_seq", out_ch, seq2[i]);
        end

        // Backpressure
        do_reset(1);
        in_valid = 4'b1111;
        cycle();
        check("bp_first", out_ch, 0);
        out_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("bp_hold_ch", out_ch, 0);
            check("bp_hold_data", out_data, 8'h10);
            check("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_next", out_ch, 1);

        // Reset while holding a word
        check("pre_rst_valid", out_valid, 1);
        do_reset(1);
        check("mid_rst_valid", out_valid, 0);
        cycle();
        check("post_rst_grant", out_ch, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom_range(0, 3) != 0);
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 60) == 0) rst_n = 1'b0;
            cycle();
            rst_n = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr.md
# mux_rr

Parametrised CHANNELS-to-1, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes and two selection modes. In fixed mode it forwards the channel chosen by `sel`. In round-robin mode it arbitrates fairly among all requesting channels. It sits between several producer blocks and a single consumer. It replaces hand-instantiated 2:1 select trees wherever flow control or fairness is needed.

## Interface
Parameters:
- WIDTH, 8, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SELW, $clog2(CHANNELS), width of `sel` and `out_ch` (derived; not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SELW  channel index used in fixed mode; ignored in round-robin mode
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel word-available flags
- in_ready  out  CHANNELS  per-channel accept strobes (combinational)
- out_data  out  WIDTH  registered output word
- out_ch  out  SELW  index of the channel that supplied `out_data`
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accepts the word this cycle

## Operation
- A single output register holds (out_data, out_ch). `out_valid` is its occupancy flag.
- load_en = !out_valid | out_ready. The register may be loaded when it is empty or is being drained in the same cycle.
- Grant selection (combinational, evaluated every cycle):
  - Fixed mode: grant = sel when sel < CHANNELS and in_valid[sel] = 1. Otherwise there is no grant.
  - Round-robin mode: grant = the first i with in_valid[i] = 1, searching ptr+1, ptr+2, … modulo CHANNELS, ending with ptr itself. If no channel is valid, there is no grant.
- in_ready[grant] = load_en when a grant exists. All other in_ready bits are 0. At most one in_ready bit is high per cycle.
- A transfer occurs on channel g when in_valid[g] & in_ready[g]. On the next edge:
  - out_data ← in_data slice g
  - out_ch ← g
  - out_valid ← 1
  - In round-robin mode only, ptr ← g.
- If load_en is 1 and there is no grant: out_valid ← 0. out_data and out_ch hold their last values.
- If load_en is 0: the register, out_valid and ptr all hold.
- ptr is internal, SELW bits wide, and always in the range 0..CHANNELS-1.
- Switching `mode` or `sel` affects only future grants. A word already in the register is never altered.
- Producers are expected to hold in_valid and in_data stable until accepted. The block does not check this.

## Timing
- Reset (rst_n = 0 at an edge): out_valid = 0, out_data = 0, out_ch = 0, ptr = CHANNELS-1. Channel 0 is therefore the first round-robin winner.
- Reset overrides any transfer in the same cycle. A word held in the register is discarded.
- While rst_n = 0, in_ready is all 0.
- Latency: 1 cycle from an input transfer to out_valid.
- Throughput: 1 word per clock when out_ready is held at 1.
- Backpressure: when out_valid = 1 and out_ready = 0, all in_ready bits are 0 and the register holds.
- Simultaneous drain and load in one cycle keeps out_valid = 1 with no bubble.
- Combinational paths:
  - out_ready → in_ready
  - in_valid, mode, sel → in_ready
- No combinational path exists from any input to out_data, out_ch or out_valid.
- Round-robin fairness: while every channel stays valid, each channel is granted exactly once in any window of CHANNELS consecutive transfers.

## Test plan
All scenarios use WIDTH = 8 and CHANNELS = 4 unless stated otherwise.

- Reset: with rst_n = 0 for 2 cycles and all in_valid = 1, in_ready = 0000 throughout. After release, out_valid = 0, out_data = 0x00 and out_ch = 0.
- Fixed mode: mode = 0, sel = 2, in_valid = 1111, in_data ch0..ch3 = 0x10, 0x20, 0x30, 0x40, out_ready = 1. Expect in_ready = 0100 every cycle, then out_data = 0x30 and out_ch = 2 one cycle after the first transfer. Set sel = 1 with in_valid[1] = 0: out_valid drops to 0 on the next edge.
- Round-robin rotation: mode = 1, in_valid = 1111 held, out_ready = 1. Expect out_ch to sequence 0, 1, 2, 3, 0, 1 on consecutive cycles, with no bubbles.
- Skip idle channels: mode = 1, in_valid = 1010, starting from reset. Expect out_ch to alternate 1, 3, 1, 3. ptr wrap from 3 to 1 is exercised.
- Backpressure: mode = 1, in_valid = 1111, out_ready = 0 for 3 cycles after the first load. Expect out_data, out_ch and out_valid stable and in_ready = 0000. When out_ready returns to 1, the next grant is out_ch = 1.
- Edge cases:
  - With CHANNELS = 3, mode = 0, sel = 3: in_ready = 000 and out_valid stays 0.
  - Assert rst_n = 0 while out_valid = 1: out_valid is 0 after the edge, and the next round-robin grant is channel 0.
